morty_hazard_ctrl: RTL

MORTY_HAZARD_CTRL -- requirements
Module: morty_hazard_ctrl

---
 rtl/morty_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/morty_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use bubbles,
// data-memory wait freezes, trap/xRET flushes and a saturating stall counter.
module morty_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic        ex_we_i,
  input  logic        mem_we_i,
  input  logic        wb_we_i,
  input  logic        ex_load_i,
  input  logic        mem_load_i,
  input  logic        mem_busy_i,
  input  logic        trap_i,
  input  logic        xret_i,
  output logic [1:0]  forward_a_sel_o,
  output logic [1:0]  forward_b_sel_o,
  output logic        if_stall_o,
  output logic        ex_stall_o,
  output logic        if_flush_o,
  output logic        ex_flush_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MEMW   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        cnt_r;
  logic        cnt_nxt_s;
  logic [31:0] stall_cnt_r;

  logic ex_match_a_s, mem_match_a_s, wb_match_a_s;
  logic ex_match_b_s, mem_match_b_s, wb_match_b_s;
  logic flush_req_s;
  logic ex_load_haz_s;
  logic mem_load_haz_s;
  logic if_stall_s, ex_stall_s, if_flush_s, ex_flush_s;

  // A stage only matches a live, non-x0 destination that the ID instruction actually reads.
  function automatic logic stage_match(
    input logic       we,
    input logic [4:0] waddr,
    input logic [4:0] rs,
    input logic       use_rs
  );
    return we && use_rs && (rs != 5'd0) && (waddr != 5'd0) && (waddr == rs);
  endfunction

  function automatic logic [1:0] fwd_select(
    input logic ex_m,
    input logic mem_m,
    input logic wb_m
  );
    logic [1:0] sel;
    if (ex_m) begin
      sel = 2'd1;
    end else if (mem_m) begin
      sel = 2'd2;
    end else if (wb_m) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign ex_match_a_s  = stage_match(ex_we_i,  ex_waddr_i,  id_rs1_i, id_use_rs1_i);
  assign mem_match_a_s = stage_match(mem_we_i, mem_waddr_i, id_rs1_i, id_use_rs1_i);
  assign wb_match_a_s  = stage_match(wb_we_i,  wb_waddr_i,  id_rs1_i, id_use_rs1_i);
  assign ex_match_b_s  = stage_match(ex_we_i,  ex_waddr_i,  id_rs2_i, id_use_rs2_i);
  assign mem_match_b_s = stage_match(mem_we_i, mem_waddr_i, id_rs2_i, id_use_rs2_i);
  assign wb_match_b_s  = stage_match(wb_we_i,  wb_waddr_i,  id_rs2_i, id_use_rs2_i);

  // Forward selects depend only on register addresses, never on trap/xret.
  assign forward_a_sel_o = fwd_select(ex_match_a_s, mem_match_a_s, wb_match_a_s);
  assign forward_b_sel_o = fwd_select(ex_match_b_s, mem_match_b_s, wb_match_b_s);

  assign flush_req_s    = trap_i | xret_i;
  assign ex_load_haz_s  = ex_load_i & (ex_match_a_s | ex_match_b_s);
  // A younger EX writer shadows the MEM load, so no bubble is needed for that operand.
  assign mem_load_haz_s = mem_load_i & ((mem_match_a_s & ~ex_match_a_s) |
                                        (mem_match_b_s & ~ex_match_b_s));

  // Next-state, bubble counter and control decode for the hazard FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if_stall_s  = 1'b0;
    ex_stall_s  = 1'b0;
    if_flush_s  = 1'b0;
    ex_flush_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (flush_req_s) begin
          if_flush_s  = 1'b1;
          ex_flush_s  = 1'b1;
          state_nxt_s = ST_FLUSH;
        end else if (mem_busy_i) begin
          if_stall_s  = 1'b1;
          ex_stall_s  = 1'b1;
          state_nxt_s = ST_MEMW;
        end else if (ex_load_haz_s) begin
          if_stall_s  = 1'b1;
          ex_flush_s  = 1'b1;
          cnt_nxt_s   = 1'b1;
          state_nxt_s = ST_LSTALL;
        end else if (mem_load_haz_s) begin
          if_stall_s  = 1'b1;
          ex_flush_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LSTALL: begin
        if (flush_req_s) begin
          if_flush_s  = 1'b1;
          ex_flush_s  = 1'b1;
          cnt_nxt_s   = 1'b0;
          state_nxt_s = ST_FLUSH;
        end else if (mem_busy_i) begin
          if_stall_s  = 1'b1;
          ex_stall_s  = 1'b1;
          state_nxt_s = ST_LSTALL;
        end else begin
          if_stall_s  = 1'b1;
          ex_flush_s  = 1'b1;
          cnt_nxt_s   = cnt_r - 1'b1;
          if (cnt_r == 1'b1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LSTALL;
          end
        end
      end
      ST_MEMW: begin
        if (flush_req_s) begin
          if_flush_s  = 1'b1;
          ex_flush_s  = 1'b1;
          cnt_nxt_s   = 1'b0;
          state_nxt_s = ST_FLUSH;
        end else if (mem_busy_i) begin
          if_stall_s  = 1'b1;
          ex_stall_s  = 1'b1;
          state_nxt_s = ST_MEMW;
        end else if (ex_load_haz_s) begin
          // Memory released: behave exactly as RUN would for these inputs.
          if_stall_s  = 1'b1;
          ex_flush_s  = 1'b1;
          cnt_nxt_s   = 1'b1;
          state_nxt_s = ST_LSTALL;
        end else if (mem_load_haz_s) begin
          if_stall_s  = 1'b1;
          ex_flush_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          if (cnt_r != 1'b0) begin
            state_nxt_s = ST_LSTALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if_flush_s = 1'b1;
        ex_flush_s = 1'b1;
        cnt_nxt_s  = 1'b0;
        if (flush_req_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        cnt_nxt_s   = 1'b0;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Flush always wins over stall, and reset silences every control line.
  assign if_flush_o = if_flush_s & ~rst_i;
  assign ex_flush_o = ex_flush_s & ~rst_i;
  assign if_stall_o = if_stall_s & ~if_flush_s & ~rst_i;
  assign ex_stall_o = ex_stall_s & ~if_flush_s & ~rst_i;

  // FSM state and remaining-bubble counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_RUN;
      cnt_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Stall-cycle performance counter, saturating at all ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
    end else if (if_stall_o && (stall_cnt_r != STALL_CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;

endmodule
